gray_cmd_feeder: RTL and testbench
==================================

// Module: gray_cmd_feeder
// PURPOSE
//   Command source for the gray-code sequencer FSM. Buffers 4-bit commands from a host over a
//   valid/ready interface, each with a hold count. Drives the FSM's registered cmd input, holding
//   each command for (rep+1) clocks. Presents IDLE_CMD whenever no command is active.
// PARAMETERS
//   DEPTH     4        FIFO entries; power of 2, >= 2
//   REP_W     4        width of per-command hold count
//   IDLE_CMD  4'b0000  value driven on cmd when no command is active
// PORTS
//   clk        in   1              clock, rising edge
//   rst_n      in   1              reset, asynchronous, active-low
//   in_valid   in   1              host command valid
//   in_ready   out  1              FIFO can accept (= !full)
//   in_cmd     in   4              command value
//   in_rep     in   REP_W          extra hold cycles (cmd held rep+1 clocks)
//   run        in   1              1 = advance; 0 = pause (freeze cmd, hold counter, no pop)
//   flush      in   1              sync clear of FIFO and active command
//   cmd        out  4              registered command to sequencer FSM
//   active     out  1              1 while cmd carries a popped command
//   level      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   starve     out  1              1-clk pulse: active command expired with FIFO empty, run=1
// BEHAVIOUR
//   Reset: cmd=IDLE_CMD, active=0, hold=0, level=0, FIFO ptrs=0, starve=0, in_ready=1.
//   Push: in_valid & in_ready at a rising edge writes {in_cmd,in_rep} at the wr ptr.
//   - in_ready depends only on registered level (no combinational path from pop).
//   Slot FSM, two states:
//   - IDLE:   active=0, cmd=IDLE_CMD.
//   - ACTIVE: active=1, cmd=head value, hold counter loaded with rep.
//   Pop condition ("done"): run=1 and (state==IDLE or hold==0).
//   - done & level>0: pop head; next clk cmd=head.cmd, hold=head.rep, state ACTIVE.
//   - done & level==0 & ACTIVE: next clk cmd=IDLE_CMD, state IDLE, starve=1 for that clk.
//   - ACTIVE & hold>0 & run=1: hold decrements by 1; cmd unchanged.
//   Latency: entry pushed into an empty, idle feeder appears on cmd 2 clocks after the push edge
//   (write edge, then pop edge).
//   Back-to-back: entries with rep=0 each occupy cmd for exactly 1 clk, with no IDLE gap, while
//   FIFO non-empty.
//   Simultaneous push and pop: both take effect; level unchanged. A push into a full FIFO is
//   refused even if a pop happens that cycle.
//   Wrap-around: ptrs are $clog2(DEPTH) bits and wrap naturally; level tracks full vs empty.
//   run=0: cmd, hold, state and FIFO read side frozen; pushes still accepted; starve never
//   asserts.
//   flush=1 (priority over push, pop and run):
//   - next clk: level=0, ptrs=0, cmd=IDLE_CMD, state IDLE, hold=0, starve=0.
//   - a push in the flush cycle is dropped.
//   rst_n low mid-command: immediate return to reset values; buffered entries are lost.
//   starve is registered and asserts in the same clk cmd returns to IDLE_CMD.
//   Invalid DEPTH (non power of 2 or <2): elaboration error via generate-time check.
// TESTING
//   1 Reset: rst_n low mid-run -> cmd=0000, active=0, level=0, in_ready=1 immediately,
//     asynchronously.
//   2 Hold count: push {cmd=0101,rep=2} while idle, run=1 -> cmd=0101 for 3 clks starting 2 clks
//     after the push, then 0000 with starve=1 for 1 clk.
//   3 Back-to-back: push 0001,0011,0100, all rep=0, run=1 -> cmd sequence 0001,0011,0100 on
//     consecutive clks, then idle; starve pulses once only.
//   4 Full: DEPTH=4, run=0, push 5 entries -> level=4, in_ready=0, 5th refused; set run=1 ->
//     entries 1-4 emerge in order; in_ready=1 the clk after the first pop.
//   5 Pause: while cmd=1000 with hold=3, hold run=0 for 5 clks -> cmd stays 1000; hold resumes at
//     3 once run=1.
//   6 Flush: level=3, active cmd=0110, assert flush together with a push -> next clk level=0,
//     cmd=0000, active=0, starve=0; pushed entry absent.

Source files
------------

// File: rtl/gray_cmd_feeder.sv
// gray_cmd_feeder: command source for the gray-code sequencer FSM.
// The host pushes {cmd, rep} entries into a small FIFO over valid/ready.
// A two-state slot FSM pops entries and holds each command on the registered
// cmd output for (rep+1) clocks. It presents IDLE_CMD when no command is
// active. The run input pauses the read side and flush clears everything.
module gray_cmd_feeder #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned REP_W    = 4,
  parameter logic [3:0]  IDLE_CMD = 4'b0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_cmd,
  input  logic [REP_W-1:0]         in_rep,
  input  logic                     run,
  input  logic                     flush,
  output logic [3:0]               cmd,
  output logic                     active,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     starve
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // A non power-of-2 depth would break natural pointer wrap, so reject it early.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gray_cmd_feeder: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0]       cmd;
    logic [REP_W-1:0] rep;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  state_t           r_state;
  logic [3:0]       r_cmd;
  logic [REP_W-1:0] r_hold;
  logic             r_starve;

  state_t           w_state_next;
  logic [3:0]       w_cmd_next;
  logic [REP_W-1:0] w_hold_next;
  logic             w_starve_next;

  logic             w_push;
  logic             w_done;
  logic             w_pop;
  logic             w_level_nz;
  entry_t           w_head;

  // in_ready comes only from the registered level. A pop in the same cycle
  // does not free a slot for the push.
  assign in_ready   = (r_level != LW'(DEPTH));
  assign w_level_nz = (r_level != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // The current slot is finished when we may advance and nothing is held.
  assign w_done = run && ((r_state == S_IDLE) || (r_hold == '0));
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = w_done && w_level_nz && !flush;

  assign cmd    = r_cmd;
  assign active = (r_state == S_ACTIVE);
  assign level  = r_level;
  assign starve = r_starve;

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset. The pointers and level gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= entry_t'({in_cmd, in_rep});
    end
  end

  // FIFO pointers and occupancy. Flush wins over push and pop.
  // NOTE: sequential state uses non-blocking (<=), so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Slot FSM state register together with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cmd    <= IDLE_CMD;
      r_hold   <= '0;
      r_starve <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cmd    <= w_cmd_next;
      r_hold   <= w_hold_next;
      r_starve <= w_starve_next;
    end
  end

  // Slot FSM next-state logic: pop, expire to idle with starve, or count down.
  // NOTE: every signal gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_cmd_next    = r_cmd;
    w_hold_next   = r_hold;
    w_starve_next = 1'b0;
    if (flush) begin
      w_state_next = S_IDLE;
      w_cmd_next   = IDLE_CMD;
      w_hold_next  = '0;
    end else if (w_done) begin
      if (w_level_nz) begin
        w_state_next = S_ACTIVE;
        w_cmd_next   = w_head.cmd;
        w_hold_next  = w_head.rep;
      end else if (r_state == S_ACTIVE) begin
        w_state_next  = S_IDLE;
        w_cmd_next    = IDLE_CMD;
        w_hold_next   = '0;
        w_starve_next = 1'b1;
      end
    end else if ((r_state == S_ACTIVE) && run) begin
      // Not done while active means hold > 0 here.
      w_hold_next = r_hold - REP_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_cmd_feeder.sv
// Testbench for gray_cmd_feeder. A queue-level reference model predicts every
// post-edge output into a scoreboard queue, and a monitor compares it against
// the DUT each cycle. Directed checks cover the reset, hold, back-to-back,
// full, pause and flush scenarios with literal expected values.
module tb_gray_cmd_feeder;

  localparam int         DEPTH = 4;
  localparam int         REP_W = 4;
  localparam logic [3:0] IDLE  = 4'b0000;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       in_cmd   = '0;
  logic [REP_W-1:0] in_rep   = '0;
  logic             run      = 1'b0;
  logic             flush    = 1'b0;
  logic             in_ready;
  logic [3:0]       cmd;
  logic             active;
  logic [2:0]       level;
  logic             starve;

  int n_checks = 0;
  int n_err    = 0;

  gray_cmd_feeder #(
    .DEPTH   (DEPTH),
    .REP_W   (REP_W),
    .IDLE_CMD(IDLE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_cmd  (in_cmd),
    .in_rep  (in_rep),
    .run     (run),
    .flush   (flush),
    .cmd     (cmd),
    .active  (active),
    .level   (level),
    .starve  (starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [REP_W-1:0] r,
                       input logic ru, input logic fl);
    in_valid = v;
    in_cmd   = c;
    in_rep   = r;
    run      = ru;
    flush    = fl;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [3:0]       c;
    logic [REP_W-1:0] r;
  } ent_t;

  typedef struct {
    logic [3:0] cmd;
    logic       active;
    int         level;
    logic       starve;
    logic       in_ready;
  } obs_t;

  ent_t mq[$];
  obs_t exp_q[$];

  initial begin : model
    logic [3:0] m_cmd;
    bit         m_active;
    int         m_rem;
    bit         m_starve;
    bit         acc;
    bit         done;
    ent_t       e;
    ent_t       h;
    obs_t       o;
    m_cmd = IDLE; m_active = 0; m_rem = 0; m_starve = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        exp_q.delete();
        m_cmd = IDLE; m_active = 0; m_rem = 0; m_starve = 0;
      end else begin
        if (flush) begin
          mq.delete();
          m_cmd = IDLE; m_active = 0; m_rem = 0; m_starve = 0;
        end else begin
          acc  = in_valid && (mq.size() < DEPTH);
          e.c  = in_cmd;
          e.r  = in_rep;
          done = run && (!m_active || m_rem == 0);
          m_starve = 0;
          if (done && mq.size() > 0) begin
            h = mq.pop_front();
            m_cmd = h.c; m_rem = int'(h.r); m_active = 1;
          end else if (done && m_active) begin
            m_cmd = IDLE; m_active = 0; m_starve = 1;
          end else if (m_active && run) begin
            m_rem = m_rem - 1;
          end
          if (acc) mq.push_back(e);
        end
        o.cmd      = m_cmd;
        o.active   = m_active;
        o.level    = mq.size();
        o.starve   = m_starve;
        o.in_ready = (mq.size() < DEPTH);
        exp_q.push_back(o);
      end
    end
  end

  initial begin : monitor
    obs_t o;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        o = exp_q.pop_front();
        check("sb_cmd",      32'(cmd),      32'(o.cmd));
        check("sb_active",   32'(active),   32'(o.active));
        check("sb_level",    32'(level),    32'(o.level));
        check("sb_starve",   32'(starve),   32'(o.starve));
        check("sb_in_ready", 32'(in_ready), 32'(o.in_ready));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    logic [3:0] t3_cmd [6];
    int         t3_starves;

    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    check("rst_cmd",      32'(cmd),      32'(IDLE));
    check("rst_active",   32'(active),   0);
    check("rst_level",    32'(level),    0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_starve",   32'(starve),   0);
    rst_n = 1'b1;
    tick();

    // Hold count: rep=2 gives three clocks of 0101, then an idle clock with starve.
    drive(1, 4'b0101, 4'd2, 1, 0); tick();
    check("t2_level_after_push", 32'(level), 1);
    check("t2_cmd_before_pop",   32'(cmd),   0);
    drive(0, 0, 0, 1, 0); tick();
    check("t2_cmd_c1",    32'(cmd),    5);
    check("t2_active_c1", 32'(active), 1);
    tick(); check("t2_cmd_c2", 32'(cmd), 5);
    tick(); check("t2_cmd_c3", 32'(cmd), 5);
    tick();
    check("t2_cmd_idle",   32'(cmd),    0);
    check("t2_starve",     32'(starve), 1);
    check("t2_active_off", 32'(active), 0);
    tick(); check("t2_starve_once", 32'(starve), 0);

    // Back-to-back with rep=0.
    t3_starves = 0;
    drive(1, 4'b0001, 0, 1, 0); tick();
    drive(1, 4'b0011, 0, 1, 0); tick();
    t3_cmd[0] = cmd; t3_starves += int'(starve);
    drive(1, 4'b0100, 0, 1, 0); tick();
    t3_cmd[1] = cmd; t3_starves += int'(starve);
    drive(0, 0, 0, 1, 0);
    for (int i = 2; i < 6; i++) begin
      tick();
      t3_cmd[i] = cmd; t3_starves += int'(starve);
    end
    check("t3_seq0", 32'(t3_cmd[0]), 1);
    check("t3_seq1", 32'(t3_cmd[1]), 3);
    check("t3_seq2", 32'(t3_cmd[2]), 4);
    check("t3_seq3", 32'(t3_cmd[3]), 0);
    check("t3_starve_count", 32'(t3_starves), 1);

    // Full: with run=0, five pushes leave level=4 and the fifth is refused.
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'(9 + i), 0, 0, 0);
      tick();
    end
    check("t4_level_full", 32'(level),    4);
    check("t4_not_ready",  32'(in_ready), 0);
    drive(0, 0, 0, 1, 0); tick();
    check("t4_first",      32'(cmd),      9);
    check("t4_ready_back", 32'(in_ready), 1);
    check("t4_level_3",    32'(level),    3);
    tick(); check("t4_second", 32'(cmd), 4'hA);
    tick(); check("t4_third",  32'(cmd), 4'hB);
    tick(); check("t4_fourth", 32'(cmd), 4'hC);
    tick();
    check("t4_fifth_absent", 32'(cmd),    0);
    check("t4_starve",       32'(starve), 1);

    // Pause: run=0 freezes 1000 with hold=3; countdown resumes afterwards.
    drive(1, 4'b1000, 4'd3, 1, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    check("t5_cmd_loaded", 32'(cmd), 8);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_paused_cmd",    32'(cmd),    8);
      check("t5_paused_starve", 32'(starve), 0);
    end
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_resume_cmd", 32'(cmd), 8);
    end
    tick();
    check("t5_expire_cmd",    32'(cmd),    0);
    check("t5_expire_starve", 32'(starve), 1);

    // Flush alongside a push: everything clears and the pushed entry is dropped.
    drive(1, 4'b0110, 4'd7, 1, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(1, 4'h1, 0, 0, 0); tick();
    drive(1, 4'h2, 0, 0, 0); tick();
    drive(1, 4'h3, 0, 0, 0); tick();
    check("t6_pre_level",  32'(level),  3);
    check("t6_pre_cmd",    32'(cmd),    6);
    check("t6_pre_active", 32'(active), 1);
    drive(1, 4'hF, 0, 1, 1); tick();
    check("t6_level",  32'(level),  0);
    check("t6_cmd",    32'(cmd),    0);
    check("t6_active", 32'(active), 0);
    check("t6_starve", 32'(starve), 0);
    drive(0, 0, 0, 1, 0);
    repeat (3) tick();
    check("t6_push_dropped_level", 32'(level),  0);
    check("t6_push_dropped_cmd",   32'(cmd),    0);
    check("t6_still_idle",         32'(active), 0);

    // Reset mid-command: outputs return to reset values asynchronously.
    drive(1, 4'h2, 4'd3, 1, 0); tick();
    drive(1, 4'h5, 4'd1, 1, 0); tick();
    drive(0, 0, 0, 1, 0);
    check("t1_pre_active", 32'(active), 1);
    check("t1_pre_level",  32'(level),  1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_cmd",      32'(cmd),      0);
    check("t1_async_active",   32'(active),   0);
    check("t1_async_level",    32'(level),    0);
    check("t1_async_in_ready", 32'(in_ready), 1);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t1_entries_lost_level", 32'(level),  0);
    check("t1_entries_lost_cmd",   32'(cmd),    0);

    // Randomized traffic: the scoreboard checks every cycle.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 31) == 0));
      tick();
    end
    drive(0, 0, 0, 1, 0);
    repeat (30) tick();
    check("drain_level", 32'(level),  0);
    check("drain_idle",  32'(active), 0);
    check("sb_drained",  32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
